// File: rtl/fetch_stage.sv
// Purpose : LC2K IF stage - owns the PC, fetches from combinational imem, fills IF/ID.
// Latency : word at pcCurrent appears on ifidInstr one edge later; redirect costs one bubble.
// Backpr. : stall freezes PC, IF/ID and halt state; redirect overrides stall.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   stall                 - hold PC and IF/ID this edge
//   redirect, redirectPc  - taken beq/jalr: load target, flush IF/ID, clear halt
//   instr                 - instruction memory word at pcCurrent (same cycle)
//   pcCurrent             - registered fetch address
//   ifidInstr/PcPlus1/Valid - IF/ID pipeline register
//   halted                - a halt was fetched; fetch frozen until a redirect
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] NOOP_INSTR  = 32'd29360128,
  parameter logic [2:0]  HALT_OPCODE = 3'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic [31:0] instr,
  output logic [31:0] pcCurrent,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPcPlus1,
  output logic        ifidValid,
  output logic        halted
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] ifid_instr_nxt;
  logic [31:0] ifid_pcp1_nxt;
  logic        ifid_valid_nxt;
  logic [31:0] pc_plus1;
  logic        is_halt;

  // Wraps modulo 2^32 by construction.
  assign pc_plus1 = pcCurrent + 32'd1;
  assign is_halt  = (instr[24:22] == HALT_OPCODE);

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pcCurrent;
    ifid_instr_nxt = ifidInstr;
    ifid_pcp1_nxt  = ifidPcPlus1;
    ifid_valid_nxt = ifidValid;

    if (redirect) begin
      // A halt fetched behind a taken branch was speculative, so drop it.
      state_nxt      = FETCH;
      pc_nxt         = redirectPc;
      ifid_instr_nxt = NOOP_INSTR;
      ifid_pcp1_nxt  = 32'd0;
      ifid_valid_nxt = 1'b0;
    end else if (stall) begin
      // Everything holds; a halt seen under stall is refetched later.
    end else if (state == HALTED) begin
      ifid_instr_nxt = NOOP_INSTR;
      ifid_pcp1_nxt  = 32'd0;
      ifid_valid_nxt = 1'b0;
    end else begin
      ifid_instr_nxt = instr;
      ifid_pcp1_nxt  = pc_plus1;
      ifid_valid_nxt = 1'b1;
      if (is_halt) begin
        // The halt word itself goes down the pipe; the PC parks on it.
        state_nxt = HALTED;
      end else begin
        pc_nxt = pc_plus1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pcCurrent   <= RESET_PC;
      ifidInstr   <= NOOP_INSTR;
      ifidPcPlus1 <= 32'd0;
      ifidValid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pcCurrent   <= pc_nxt;
      ifidInstr   <= ifid_instr_nxt;
      ifidPcPlus1 <= ifid_pcp1_nxt;
      ifidValid   <= ifid_valid_nxt;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized stall/redirect/reset traffic, all checked every edge against a
// word-level model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOOP = 32'd29360128;
  localparam logic [31:0] FILL = 32'd655361;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'd0;
  logic [31:0] instr;
  logic [31:0] pcCurrent, ifidInstr, ifidPcPlus1;
  logic        ifidValid, halted;

  logic [31:0] mem [0:15];

  int n_total = 0;
  int n_pass  = 0;
  bit started = 1'b0;

  // model state
  logic [31:0] m_pc, m_ii, m_ip1;
  logic        m_v, m_h;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .instr      (instr),
    .pcCurrent  (pcCurrent),
    .ifidInstr  (ifidInstr),
    .ifidPcPlus1(ifidPcPlus1),
    .ifidValid  (ifidValid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wordat(input logic [31:0] a);
    if (a < 32'd16) return mem[a[3:0]];
    return FILL;
  endfunction

  // combinational instruction memory
  always @* instr = wordat(pcCurrent);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: one step per clock edge, reset resets immediately.
  always @(posedge clk or posedge reset) begin
    logic [31:0] w;
    if (reset) begin
      m_pc = 32'd0; m_ii = NOOP; m_ip1 = 32'd0; m_v = 1'b0; m_h = 1'b0;
      started = 1'b1;
    end else if (redirect) begin
      m_pc = redirectPc; m_ii = NOOP; m_ip1 = 32'd0; m_v = 1'b0; m_h = 1'b0;
    end else if (stall) begin
      // hold
    end else if (m_h) begin
      m_ii = NOOP; m_ip1 = 32'd0; m_v = 1'b0;
    end else begin
      w     = wordat(m_pc);
      m_ii  = w;
      m_ip1 = m_pc + 32'd1;
      m_v   = 1'b1;
      if (w[24:22] == 3'd6) m_h = 1'b1;
      else m_pc = m_pc + 32'd1;
    end
    #1;
    if (started) begin
      chk("pcCurrent",   pcCurrent,   m_pc);
      chk("ifidInstr",   ifidInstr,   m_ii);
      chk("ifidPcPlus1", ifidPcPlus1, m_ip1);
      chk("ifidValid",   {31'd0, ifidValid}, {31'd0, m_v});
      chk("halted",      {31'd0, halted},    {31'd0, m_h});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] img [0:8];
    logic [31:0] w;
    img = '{32'd8454154, 32'd8519689, 32'd655361, 32'd29360128, 32'd655361,
            32'd29360128, 32'd655361, 32'd29360128, 32'd25165824};
    for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? img[i] : FILL;

    // 1: straight run into halt
    do_reset();
    chk("t1 reset pc", pcCurrent, 32'd0);
    chk("t1 reset instr", ifidInstr, NOOP);
    step(4);
    chk("t1 e4 instr", ifidInstr, 32'd29360128);
    chk("t1 e4 pcp1", ifidPcPlus1, 32'd4);
    chk("t1 e4 pc", pcCurrent, 32'd4);
    step(5);
    chk("t1 e9 instr", ifidInstr, 32'd25165824);
    chk("t1 e9 valid", {31'd0, ifidValid}, 32'd1);
    chk("t1 e9 halted", {31'd0, halted}, 32'd1);
    chk("t1 e9 pc", pcCurrent, 32'd8);
    step(2);
    chk("t1 e11 valid", {31'd0, ifidValid}, 32'd0);
    chk("t1 e11 pc", pcCurrent, 32'd8);

    // 2: stall for two cycles at pc=3
    do_reset();
    step(3);
    stall = 1'b1;
    step(2);
    chk("t2 stall pc", pcCurrent, 32'd3);
    chk("t2 stall instr", ifidInstr, 32'd655361);
    chk("t2 stall pcp1", ifidPcPlus1, 32'd3);
    stall = 1'b0;
    step(1);
    chk("t2 resume instr", ifidInstr, 32'd29360128);
    chk("t2 resume pcp1", ifidPcPlus1, 32'd4);

    // 3: redirect to 5 from pc=2
    do_reset();
    step(2);
    redirect = 1'b1; redirectPc = 32'd5;
    step(1);
    redirect = 1'b0;
    chk("t3 redir pc", pcCurrent, 32'd5);
    chk("t3 redir valid", {31'd0, ifidValid}, 32'd0);
    chk("t3 redir instr", ifidInstr, NOOP);
    step(1);
    chk("t3 after pcp1", ifidPcPlus1, 32'd6);
    chk("t3 after valid", {31'd0, ifidValid}, 32'd1);

    // 4: redirect beats stall; redirect releases halt
    redirect = 1'b1; stall = 1'b1; redirectPc = 32'd7;
    step(1);
    redirect = 1'b0; stall = 1'b0;
    chk("t4 rs pc", pcCurrent, 32'd7);
    chk("t4 rs valid", {31'd0, ifidValid}, 32'd0);
    step(3);
    chk("t4 halted", {31'd0, halted}, 32'd1);
    redirect = 1'b1; redirectPc = 32'd0;
    step(1);
    redirect = 1'b0;
    chk("t4 unhalt", {31'd0, halted}, 32'd0);
    chk("t4 unhalt pc", pcCurrent, 32'd0);
    step(1);
    chk("t4 restart instr", ifidInstr, 32'd8454154);

    // 5: asynchronous reset between edges
    do_reset();
    step(6);
    chk("t5 pre pc", pcCurrent, 32'd6);
    chk("t5 pre valid", {31'd0, ifidValid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5 async pc", pcCurrent, 32'd0);
    chk("t5 async valid", {31'd0, ifidValid}, 32'd0);
    chk("t5 async instr", ifidInstr, NOOP);
    @(negedge clk);
    reset = 1'b0;
    step(1);
    chk("t5 first instr", ifidInstr, 32'd8454154);
    chk("t5 first pcp1", ifidPcPlus1, 32'd1);

    // 6: PC wrap
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFF;
    step(1);
    redirect = 1'b0;
    chk("t6 pc max", pcCurrent, 32'hFFFF_FFFF);
    step(1);
    chk("t6 wrap pcp1", ifidPcPlus1, 32'd0);
    chk("t6 wrap pc", pcCurrent, 32'd0);
    chk("t6 wrap instr", ifidInstr, FILL);

    // randomized traffic, model-checked every edge
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) == 0) w[24:22] = 3'd6;
      else if (w[24:22] == 3'd6) w[24:22] = 3'd0;
      mem[i] = w;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 6) == 0);
      redirectPc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        #4 reset = 1'b0;
      end
      @(negedge clk);
    end
    stall = 1'b0; redirect = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
